// File: rtl/window_3x3_stream.sv
// 3x3 window generator: turns a padded raster pixel stream into one
// convolution window per valid output position, behind a single output
// register stage. Two line buffers hold the previous two rows.
module window_3x3_stream #(
   parameter int MAX_XRES = 1024,
   parameter int DW       = 16
) (
   input  logic            clock,
   input  logic            clock_reset_n,
   output logic            si_ready,
   input  logic            si_valid,
   input  logic            si_sop,
   input  logic            si_eop,
   input  logic [DW-1:0]   si_data,
   input  logic            so_ready,
   output logic            so_valid,
   output logic            so_sop,
   output logic            so_eop,
   output logic [9*DW-1:0] so_data
);

   localparam int AW = (MAX_XRES > 1) ? $clog2(MAX_XRES) : 1;

   typedef enum logic [2:0] {S_HX, S_HY, S_OX, S_OY, S_PIX, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [11:0]            xres_q, xres_d, yres_q, yres_d;
   logic [11:0]            cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
   // col_q[c] holds one window column; row r sits at [DW*r +: DW], row 0 oldest
   logic [2:0][3*DW-1:0]   col_q, col_d, col_sh;
   logic                   so_valid_q, so_valid_d, so_sop_q, so_sop_d, so_eop_q, so_eop_d;
   logic [9*DW-1:0]        so_data_q, so_data_d, win;
   logic [DW-1:0]          lb0_q [MAX_XRES];
   logic [DW-1:0]          lb1_q [MAX_XRES];
   logic [AW-1:0]          lb_addr;
   logic                   in_xfer, pix_acc, last_pix;

   assign so_valid = so_valid_q;
   assign so_sop   = so_sop_q;
   assign so_eop   = so_eop_q;
   assign so_data  = so_data_q;

   assign lb_addr  = cnt_x_q[AW-1:0];
   assign in_xfer  = si_valid & si_ready;
   assign pix_acc  = in_xfer & (state_q == S_PIX);
   assign last_pix = (cnt_x_q == xres_q - 12'd1) && (cnt_y_q == yres_q - 12'd1);
   // Window shifted left by one column, new column = {pixel, lb1, lb0} bottom to top
   assign col_sh   = {{si_data, lb1_q[lb_addr], lb0_q[lb_addr]}, col_q[2], col_q[1]};

   // Input is accepted freely in header/drain states, throttled by the output register in S_PIX
   always_comb begin
      si_ready = 1'b0;
      case (state_q)
         S_HX, S_HY, S_DRAIN: si_ready = 1'b1;
         S_PIX:               si_ready = ~so_valid_q | so_ready;
         default:             si_ready = 1'b0;
      endcase
   end

   // Flatten the shifted columns into the row-major output window
   always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            win[DW*(3*r+c) +: DW] = col_sh[c][DW*r +: DW];
   end

   // Next-state logic for FSM, counters, window and output register
   always_comb begin
      state_d    = state_q;
      xres_d     = xres_q;
      yres_d     = yres_q;
      cnt_x_d    = cnt_x_q;
      cnt_y_d    = cnt_y_q;
      col_d      = col_q;
      so_valid_d = so_valid_q;
      so_sop_d   = so_sop_q;
      so_eop_d   = so_eop_q;
      so_data_d  = so_data_q;
      if (so_ready) begin
         so_valid_d = 1'b0;
         so_sop_d   = 1'b0;
         so_eop_d   = 1'b0;
      end
      case (state_q)
         S_HX: if (in_xfer && si_sop) begin
            xres_d  = si_data[11:0];
            state_d = S_HY;
         end
         S_HY: if (in_xfer) begin
            yres_d = si_data[11:0];
            if (xres_q < 12'd3 || si_data[11:0] < 12'd3 || xres_q > 12'(MAX_XRES))
               state_d = S_DRAIN;
            else
               state_d = S_OX;
         end
         // The output register may still hold the previous frame's eop window;
         // only the x header carries sop, which tells the two apart.
         S_OX: begin
            if (so_valid_q && so_sop_q) begin
               if (so_ready) begin
                  so_valid_d = 1'b1;
                  so_sop_d   = 1'b0;
                  so_eop_d   = 1'b0;
                  so_data_d  = {{(9*DW-12){1'b0}}, yres_q - 12'd2};
                  state_d    = S_OY;
               end
            end else if (~so_valid_q | so_ready) begin
               so_valid_d = 1'b1;
               so_sop_d   = 1'b1;
               so_eop_d   = 1'b0;
               so_data_d  = {{(9*DW-12){1'b0}}, xres_q - 12'd2};
            end
         end
         S_OY: if (so_ready) begin
            cnt_x_d = '0;
            cnt_y_d = '0;
            state_d = S_PIX;
         end
         S_PIX: if (pix_acc) begin
            col_d = col_sh;
            if (cnt_x_q == xres_q - 12'd1) begin
               cnt_x_d = '0;
               cnt_y_d = cnt_y_q + 12'd1;
            end else begin
               cnt_x_d = cnt_x_q + 12'd1;
            end
            if (cnt_x_q >= 12'd2 && cnt_y_q >= 12'd2) begin
               so_valid_d = 1'b1;
               so_sop_d   = 1'b0;
               so_eop_d   = last_pix;
               so_data_d  = win;
            end
            if (last_pix) state_d = S_HX;
         end
         S_DRAIN: if (in_xfer && si_eop) state_d = S_HX;
         default: state_d = S_HX;
      endcase
   end

   // Control and output registers
   always_ff @(posedge clock or negedge clock_reset_n) begin
      if (!clock_reset_n) begin
         state_q    <= S_HX;
         xres_q     <= '0;
         yres_q     <= '0;
         cnt_x_q    <= '0;
         cnt_y_q    <= '0;
         col_q      <= '0;
         so_valid_q <= 1'b0;
         so_sop_q   <= 1'b0;
         so_eop_q   <= 1'b0;
         so_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         xres_q     <= xres_d;
         yres_q     <= yres_d;
         cnt_x_q    <= cnt_x_d;
         cnt_y_q    <= cnt_y_d;
         col_q      <= col_d;
         so_valid_q <= so_valid_d;
         so_sop_q   <= so_sop_d;
         so_eop_q   <= so_eop_d;
         so_data_q  <= so_data_d;
      end
   end

   // Line buffers: lb1 keeps the previous row, lb0 the one before it
   always_ff @(posedge clock) begin
      if (pix_acc) begin
         lb0_q[lb_addr] <= lb1_q[lb_addr];
         lb1_q[lb_addr] <= si_data;
      end
   end

endmodule

// File: tb/tb_window_3x3_stream.sv
// Bench for window_3x3_stream: frames are built as beat queues, and the
// expected output is derived directly from the 2D pixel image.
module tb_window_3x3_stream;
   localparam int DW   = 16;
   localparam int MAXX = 1024;
   localparam int OW   = 9*DW;

   logic          clock = 1'b0;
   logic          clock_reset_n = 1'b0;
   logic          si_ready, si_valid, si_sop, si_eop;
   logic [DW-1:0] si_data;
   logic          so_ready, so_valid, so_sop, so_eop;
   logic [OW-1:0] so_data;

   window_3x3_stream #(.MAX_XRES(MAXX), .DW(DW)) dut (
      .clock(clock), .clock_reset_n(clock_reset_n),
      .si_ready(si_ready), .si_valid(si_valid), .si_sop(si_sop), .si_eop(si_eop), .si_data(si_data),
      .so_ready(so_ready), .so_valid(so_valid), .so_sop(so_sop), .so_eop(so_eop), .so_data(so_data)
   );

   always #5 clock = ~clock;

   // kind: 0 = header/discarded beat, 1 = pixel without window, 2 = pixel that completes a window
   typedef struct { logic sop; logic eop; logic [DW-1:0] data; int kind; } beat_t;
   typedef struct { logic sop; logic eop; logic [OW-1:0] data; } out_t;

   beat_t in_q[$];
   out_t  exp_q[$];
   int    n_assert = 0, n_fail = 0;
   int    rmode = 0, gaps = 0, rcnt = 0, prev_kind = 0, n_acc = 0;
   logic  prev_rdy = 1'b0;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input logic sop, input logic eop, input logic [DW-1:0] d, input int kind);
      beat_t b;
      b.sop = sop; b.eop = eop; b.data = d; b.kind = kind;
      in_q.push_back(b);
   endtask

   // Reference model: base<0 gives random pixels, else pixels base, base+1, ...
   task automatic add_frame(input int xr, input int yr, input int base);
      logic [DW-1:0] pix[$];
      out_t o;
      bit ok;
      ok = (xr >= 3) && (yr >= 3) && (xr <= MAXX);
      for (int i = 0; i < xr*yr; i++) pix.push_back(base < 0 ? DW'($urandom) : DW'(base + i));
      push_beat(1'b1, 1'b0, DW'(xr), 0);
      push_beat(1'b0, 1'b0, DW'(yr), 0);
      for (int y = 0; y < yr; y++)
         for (int x = 0; x < xr; x++)
            push_beat(1'b0, (y == yr-1) && (x == xr-1), pix[y*xr+x],
                      !ok ? 0 : ((x >= 2 && y >= 2) ? 2 : 1));
      if (ok) begin
         o.sop = 1'b1; o.eop = 1'b0; o.data = OW'(xr - 2); exp_q.push_back(o);
         o.sop = 1'b0; o.data = OW'(yr - 2); exp_q.push_back(o);
         for (int oy = 0; oy < yr-2; oy++)
            for (int ox = 0; ox < xr-2; ox++) begin
               o.data = '0;
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++)
                     o.data[DW*(3*r+c) +: DW] = pix[(oy+r)*xr + ox + c];
               o.sop = 1'b0;
               o.eop = (oy == yr-3) && (ox == xr-3);
               exp_q.push_back(o);
            end
      end
   endtask

   // One clock cycle: drive at negedge, sample mid-cycle, then advance on posedge
   task automatic step();
      logic in_x;
      int   kind;
      @(negedge clock);
      case (rmode)
         0:       so_ready = 1'b1;
         1:       so_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
         default: so_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
      if (in_q.size() != 0) begin
         si_valid = (gaps == 0) || ($urandom_range(0, 3) != 0);
         si_sop   = in_q[0].sop;
         si_eop   = in_q[0].eop;
         si_data  = in_q[0].data;
         kind     = in_q[0].kind;
      end else begin
         si_valid = 1'b0; si_sop = 1'b0; si_eop = 1'b0; si_data = '0; kind = 0;
      end
      #1;
      if (prev_kind == 2) chk("win_latency", OW'(so_valid), OW'(1));
      else if (prev_kind == 1 && prev_rdy) chk("no_win_out", OW'(so_valid), OW'(0));
      if (kind != 0 && so_valid === 1'b1 && !so_ready) chk("held_si_ready", OW'(si_ready), OW'(0));
      if (so_valid === 1'b1 && so_ready) begin
         chk("unexpected_out", OW'(exp_q.size() != 0), OW'(1));
         if (exp_q.size() != 0) begin
            chk("out_sop",  OW'(so_sop),  OW'(exp_q[0].sop));
            chk("out_eop",  OW'(so_eop),  OW'(exp_q[0].eop));
            chk("out_data", so_data,      exp_q[0].data);
            void'(exp_q.pop_front());
         end
      end
      in_x     = si_valid && (si_ready === 1'b1);
      prev_rdy = so_ready;
      @(posedge clock);
      if (in_x) begin
         void'(in_q.pop_front());
         n_acc++;
      end
      prev_kind = in_x ? kind : 0;
   endtask

   task automatic run(input int budget);
      int cyc = 0;
      while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
         step();
         cyc++;
      end
      chk("timeout", OW'(in_q.size() == 0 && exp_q.size() == 0), OW'(1));
      in_q.delete();
      exp_q.delete();
      repeat (5) step();
   endtask

   initial begin
      si_valid = 1'b0; si_sop = 1'b0; si_eop = 1'b0; si_data = '0; so_ready = 1'b0;
      #12;
      // Reset state
      chk("rst_so_valid", OW'(so_valid), OW'(0));
      chk("rst_so_sop",   OW'(so_sop),   OW'(0));
      chk("rst_so_eop",   OW'(so_eop),   OW'(0));
      chk("rst_so_data",  so_data,       OW'(0));
      @(negedge clock);
      clock_reset_n = 1'b1;
      #1 chk("rst_si_ready", OW'(si_ready), OW'(1));

      // 5x5 counting frame, output always ready, with a discarded non-sop beat first
      rmode = 0; gaps = 0;
      push_beat(1'b0, 1'b0, DW'(77), 0);
      add_frame(5, 5, 1);
      run(500);

      // Same frame under 1,0,0,1 backpressure
      rmode = 1; rcnt = 0;
      add_frame(5, 5, 1);
      run(1000);

      // Degenerate 2x7 frame drained, then a 4x4 frame
      rmode = 0;
      add_frame(2, 7, 100);
      add_frame(4, 4, 200);
      run(500);

      // Back-to-back 3x3 frames
      add_frame(3, 3, 1);
      add_frame(3, 3, 10);
      run(500);

      // Stray eop/sop inside pixel data are plain data
      add_frame(4, 3, 50);
      in_q[in_q.size()-7].eop = 1'b1;
      in_q[in_q.size()-6].sop = 1'b1;
      run(500);

      // Reset mid-frame while the first window sits in the output register
      add_frame(5, 5, 1);
      n_acc = 0;
      for (int i = 0; i < 500 && n_acc < 15; i++) step();
      @(negedge clock);
      so_ready = 1'b0;
      si_valid = 1'b0;
      #1 chk("pre_rst_valid", OW'(so_valid), OW'(1));
      clock_reset_n = 1'b0;
      #1;
      chk("async_rst_valid", OW'(so_valid), OW'(0));
      chk("async_rst_data",  so_data,       OW'(0));
      in_q.delete();
      exp_q.delete();
      prev_kind = 0;
      @(negedge clock);
      clock_reset_n = 1'b1;
      add_frame(5, 5, 1);
      run(500);

      // Random frames with random backpressure and input gaps
      rmode = 2; gaps = 1;
      for (int f = 0; f < 4; f++) add_frame(int'($urandom_range(3, 9)), int'($urandom_range(3, 6)), -1);
      run(4000);

      // Widest line
      rmode = 0; gaps = 0;
      add_frame(MAXX, 3, -1);
      run(8000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/window_3x3_stream.md
Name: window_3x3_stream

Overview:
- Converts the zero-padded pixel stream produced by the padding stage into a stream of 3x3 convolution windows, one window per valid output position.
- Sits directly downstream of the padder and feeds the convolution MAC array.
- Input frame format: header beat xres (sop), header beat yres, then xres*yres pixels in raster order; the last pixel carries eop.
- Output frame format: header beat xres-2 (sop), header beat yres-2, then (xres-2)*(yres-2) windows; the last window carries eop.

Parameters:
- MAX_XRES, 1024: line-buffer depth, i.e. the largest accepted input xres.
- DW, 16: pixel width in bits.

Ports:
- clock  in  1  rising-edge clock.
- clock_reset_n  in  1  asynchronous, active-low reset.
- si_ready  out  1  input ready.
- si_valid  in  1  input beat valid.
- si_sop  in  1  input start of frame (first header beat).
- si_eop  in  1  input end of frame (last pixel).
- si_data  in  DW  header value in [11:0], or pixel.
- so_ready  in  1  output ready.
- so_valid  out  1  output beat valid.
- so_sop  out  1  output start of frame.
- so_eop  out  1  output end of frame.
- so_data  out  9*DW  window; header beats use [11:0], all other bits zero.

Behaviour:
- Reset, asynchronous and active-low: so_valid=0, so_sop=0, so_eop=0, so_data=0, counters=0, fsm=S_HX. Assertion mid-frame abandons that frame.
- Handshake:
  - An input beat transfers when si_valid & si_ready.
  - An output beat transfers when so_valid & so_ready.
  - The output is a single register stage: it holds its value while so_valid & ~so_ready.
- si_ready is combinational:
  - S_HX, S_HY, S_DRAIN: 1.
  - S_PIX: ~so_valid | so_ready.
  - Other states: 0.
- FSM:
  - S_HX: latch xres=si_data[11:0] on a transfer with si_sop. Beats without si_sop are discarded. Go to S_HY.
  - S_HY: latch yres on transfer. If xres<3, yres<3 or xres>MAX_XRES, go to S_DRAIN; else go to S_OX.
  - S_OX: present header xres-2 with so_sop=1. On output transfer, go to S_OY.
  - S_OY: present header yres-2 with so_sop=0. On output transfer, clear count_x/count_y and go to S_PIX.
  - S_PIX: on each accepted pixel:
    - Write the pixel into line buffer 1 at count_x.
    - Move the old line-buffer-1 entry to line buffer 0.
    - Shift a 3-column window register left, loading the new column {lb0, lb1, pixel}.
    - Advance count_x; wrap to 0 at xres-1 and increment count_y.
  - S_PIX output: when count_x>=2 && count_y>=2 at acceptance, the next cycle presents so_valid=1 with the updated window (latency 1 cycle). Other accepted pixels produce no output.
  - S_PIX exit: after accepting pixel (xres-1, yres-1), the emitted window carries so_eop=1 and the FSM returns to S_HX.
  - S_DRAIN: accept and discard beats until a transfer with si_eop, then return to S_HX. No output.
- Window layout: so_data[DW*(3*r+c) +: DW], where r=0 is the top (oldest) row and c=0 is the leftmost (oldest) column.
- si_eop inside S_PIX before the expected count is ignored; termination is by count only.
- An early si_sop in S_PIX is treated as data.
- Line buffers are 2 x MAX_XRES x DW. They may be inferred RAM with the read prefetched one pixel ahead; the 1-cycle latency holds regardless.
- Widths:
  - Counters are 12 bits.
  - xres-2 and yres-2 are computed in 12 bits and zero-extended.
  - Throughput is 1 pixel per cycle when so_ready=1.
- so_sop/so_eop are valid only while so_valid=1 and are deasserted once the beat transfers.

Test Plan:
- Header 5,5 plus pixels 1..25, so_ready=1:
  - Output headers 3 then 3, followed by 9 windows.
  - First window = {1,2,3,6,7,8,11,12,13}.
  - Last window = {13,14,15,18,19,20,23,24,25} with eop.
  - Each window appears 1 cycle after its pixel is accepted.
- Same frame with so_ready toggling 1,0,0,1 repeating: identical output sequence, no drops or duplicates, and si_ready low whenever output is held.
- Header 2,7: all 16 beats consumed, zero output beats, and the next 4,4 frame produces headers 2,2 and 4 windows.
- Two back-to-back 3x3 frames (pixels 1..9, then 10..18): outputs are headers 1,1,{1..9} eop, then headers 1,1,{10..18} eop, with no stale line-buffer data.
- Reset pulled low after pixel 12 of a 5x5 frame: so_valid falls to 0 asynchronously, and a fresh 5x5 frame then matches scenario 1.
- Header xres=MAX_XRES, yres=3: exactly MAX_XRES-2 windows out, and the last window has eop.
